debug_unit_ctrl: RTL and testbench

//  Debug-unit controller between the UART core and the MIPS pipeline inside TOP_MIPS.
//  It assembles UART bytes into 32-bit instructions and writes them to instruction memory.
//  It accepts run/step commands, gates the pipeline enable, and dumps PC, registers and data memory over UART TX.

---
 rtl/debug_pkg.sv | 18 +
 rtl/word_tx_serializer.sv | 59 +++++
 rtl/debug_unit_ctrl.sv | 160 ++++++++++++++++
 tb/tb_debug_unit_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared constants and state encoding for the MIPS debug-unit controller.
package debug_pkg;

  localparam logic [7:0]  CMD_RUN    = 8'hFF;
  localparam logic [7:0]  CMD_STEP   = 8'hAA;
  localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;
  localparam int          DUMP_BYTES = 260;

  typedef enum logic [2:0] {
    LOAD,
    WAIT_CMD,
    RUN,
    STEP,
    DUMP,
    HALTED
  } state_t;

endpackage

// File: rtl/word_tx_serializer.sv
// Sends one CPU word as UART bytes, LSB first, using the tx_signal/tx_done handshake.
module word_tx_serializer #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DATA_WIDTH-1:0]      word,
  input  logic                       tx_done,
  output logic                       tx_signal,
  output logic [DATA_WIDTH_UART-1:0] tx_data,
  output logic                       done
);

  localparam int NBYTES = DATA_WIDTH / DATA_WIDTH_UART;
  localparam int IDX_W  = $clog2(NBYTES);

  logic [DATA_WIDTH-1:0] latched;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      nidx;
  logic                  busy;

  assign nidx = idx + 1'b1;

  // The word is captured once; every byte is taken from this copy, not the live input.
  always_ff @(posedge clock) begin
    if (start && !busy) latched <= word;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_signal <= 1'b0;
      tx_data   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      idx       <= '0;
    end else begin
      tx_signal <= 1'b0;
      done      <= 1'b0;
      if (start && !busy) begin
        idx       <= '0;
        tx_data   <= word[DATA_WIDTH_UART-1:0];
        tx_signal <= 1'b1;
        busy      <= 1'b1;
      end else if (busy && !tx_signal && tx_done) begin
        if (idx == IDX_W'(NBYTES - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          idx       <= nidx;
          tx_data   <= latched[DATA_WIDTH_UART*int'(nidx) +: DATA_WIDTH_UART];
          tx_signal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_unit_ctrl.sv
// Debug-unit controller: loads instruction memory from UART, runs/steps the pipeline,
// then dumps PC, register file and data memory back over UART.
module debug_unit_ctrl
  import debug_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int IMEM_ADDR_WIDTH = 5,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int DMEM_ADDR_WIDTH = 5
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_rx_done,
  input  logic [DATA_WIDTH_UART-1:0] i_rx_data,
  input  logic                       i_tx_done,
  output logic                       o_tx_signal,
  output logic [DATA_WIDTH_UART-1:0] o_tx_data,
  output logic                       o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [DATA_WIDTH-1:0]      o_imem_wdata,
  output logic                       o_cpu_enable,
  input  logic                       i_halt,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  output logic [REG_ADDR_WIDTH-1:0]  o_reg_addr,
  input  logic [DATA_WIDTH-1:0]      i_reg_data,
  output logic [DMEM_ADDR_WIDTH-1:0] o_dmem_addr,
  input  logic [DATA_WIDTH-1:0]      i_dmem_data
);

  localparam int WORD_BYTES = DATA_WIDTH / DATA_WIDTH_UART;
  localparam int BYTE_W     = $clog2(WORD_BYTES);
  localparam int REG_BASE   = WORD_BYTES;
  localparam int DMEM_BASE  = WORD_BYTES * (1 + 2**REG_ADDR_WIDTH);

  state_t                     state;
  logic [BYTE_W-1:0]          byte_cnt;
  logic [IMEM_ADDR_WIDTH-1:0] addr_cnt;
  logic [DATA_WIDTH-1:0]      word_buf;
  logic [DATA_WIDTH-1:0]      load_word;
  logic                       halted;
  logic [8:0]                 dump_cnt;
  logic [8:0]                 dump_nxt;
  logic [REG_ADDR_WIDTH-1:0]  next_addr;
  logic [DATA_WIDTH-1:0]      dump_word;
  logic                       ser_start;
  logic                       ser_done;

  always_comb begin
    load_word = word_buf;
    load_word[DATA_WIDTH_UART*int'(byte_cnt) +: DATA_WIDTH_UART] = i_rx_data;
  end

  // dump_cnt is the byte offset of the word being started, so it selects the source.
  always_comb begin
    dump_word = i_dmem_data;
    if (dump_cnt < 9'(REG_BASE))       dump_word = i_pc;
    else if (dump_cnt < 9'(DMEM_BASE)) dump_word = i_reg_data;
  end

  assign dump_nxt  = dump_cnt + 9'(WORD_BYTES);
  // Register and dmem regions are both 32 words, so one index serves both addresses.
  assign next_addr = REG_ADDR_WIDTH'((dump_nxt / 9'(WORD_BYTES)) - 9'd1);

  always_ff @(posedge i_clock) begin
    if (state == LOAD && i_rx_done) word_buf <= load_word;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= LOAD;
      byte_cnt     <= '0;
      addr_cnt     <= '0;
      halted       <= 1'b0;
      dump_cnt     <= '0;
      ser_start    <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_cpu_enable <= 1'b0;
      o_reg_addr   <= '0;
      o_dmem_addr  <= '0;
    end else begin
      o_imem_we <= 1'b0;
      ser_start <= 1'b0;
      case (state)
        LOAD: begin
          if (i_rx_done) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == '1) begin
              o_imem_we    <= 1'b1;
              o_imem_wdata <= load_word;
              o_imem_addr  <= addr_cnt;
              addr_cnt     <= addr_cnt + 1'b1;
              if (load_word == HALT_INSTR || addr_cnt == '1) state <= WAIT_CMD;
            end
          end
        end
        WAIT_CMD: begin
          if (i_rx_done && i_rx_data == CMD_RUN) begin
            state        <= RUN;
            o_cpu_enable <= 1'b1;
          end else if (i_rx_done && i_rx_data == CMD_STEP) begin
            state        <= STEP;
            o_cpu_enable <= 1'b1;
          end
        end
        RUN: begin
          if (i_halt) begin
            o_cpu_enable <= 1'b0;
            halted       <= 1'b1;
            state        <= DUMP;
            dump_cnt     <= '0;
            ser_start    <= 1'b1;
            o_reg_addr   <= '0;
            o_dmem_addr  <= '0;
          end
        end
        STEP: begin
          o_cpu_enable <= 1'b0;
          halted       <= halted | i_halt;
          state        <= DUMP;
          dump_cnt     <= '0;
          ser_start    <= 1'b1;
          o_reg_addr   <= '0;
          o_dmem_addr  <= '0;
        end
        DUMP: begin
          if (ser_done) begin
            dump_cnt <= dump_nxt;
            if (dump_nxt == 9'(DUMP_BYTES)) begin
              state <= halted ? HALTED : WAIT_CMD;
            end else begin
              ser_start   <= 1'b1;
              o_reg_addr  <= next_addr;
              o_dmem_addr <= DMEM_ADDR_WIDTH'(next_addr);
            end
          end
        end
        HALTED:  o_cpu_enable <= 1'b0;
        default: state <= LOAD;
      endcase
    end
  end

  word_tx_serializer #(
    .DATA_WIDTH      (DATA_WIDTH),
    .DATA_WIDTH_UART (DATA_WIDTH_UART)
  ) u_serializer (
    .clock     (i_clock),
    .reset     (i_reset),
    .start     (ser_start),
    .word      (dump_word),
    .tx_done   (i_tx_done),
    .tx_signal (o_tx_signal),
    .tx_data   (o_tx_data),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Directed bench for debug_unit_ctrl with a queue-based model of expected writes and dump bytes.
module tb_debug_unit_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_done = 1'b0;
  logic        tx_signal;
  logic [7:0]  tx_data;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_enable;
  logic        halt = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [4:0]  dmem_addr;
  logic [31:0] dmem_data;

  logic [31:0] regs [32];
  logic [31:0] dmem [32];

  int checks = 0;
  int errors = 0;
  int en_cycles = 0;
  int tx_pulses = 0;
  int dump_pulses = 0;
  int run_cnt = 0;
  bit halt_arm = 0;
  logic [7:0]  first_bytes [4];
  logic [31:0] im_addr_q [$];
  logic [31:0] im_data_q [$];
  logic [7:0]  tx_q [$];

  always #5 clock = ~clock;

  assign reg_data  = regs[reg_addr];
  assign dmem_data = dmem[dmem_addr];

  debug_unit_ctrl dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_rx_done    (rx_done),
    .i_rx_data    (rx_data),
    .i_tx_done    (tx_done),
    .o_tx_signal  (tx_signal),
    .o_tx_data    (tx_data),
    .o_imem_we    (imem_we),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_cpu_enable (cpu_enable),
    .i_halt       (halt),
    .i_pc         (pc),
    .o_reg_addr   (reg_addr),
    .i_reg_data   (reg_data),
    .o_dmem_addr  (dmem_addr),
    .i_dmem_data  (dmem_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Whole-dump expectation: PC, then registers, then data memory, each word LSB first.
  task automatic push_dump(input logic [31:0] pcv);
    logic [31:0] w;
    for (int k = 0; k < 65; k++) begin
      if (k == 0)       w = pcv;
      else if (k <= 32) w = regs[k-1];
      else              w = dmem[k-33];
      for (int b = 0; b < 4; b++) tx_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clock);
    rx_done = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic load_word(input logic [31:0] w, input int addr);
    im_addr_q.push_back(32'(addr));
    im_data_q.push_back(w);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
  endtask

  task automatic wait_dump_done(input string name);
    int n = 0;
    while (tx_q.size() != 0 && n < 6000) begin
      @(negedge clock);
      n++;
    end
    repeat (20) @(negedge clock);
    chk(name, 32'(tx_q.size()), 32'd0);
  endtask

  // UART TX model: acknowledges each start pulse a few cycles later.
  initial begin
    int pend = 0;
    forever begin
      @(negedge clock);
      tx_done = 1'b0;
      if (reset) pend = 0;
      else if (tx_signal) pend = 3;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) tx_done = 1'b1;
      end
    end
  end

  // CPU model: raises HALT once the pipeline has been enabled for 40 cycles.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (halt_arm && cpu_enable) begin
        run_cnt++;
        if (run_cnt == 40) begin
          halt = 1'b1;
          halt_arm = 0;
        end
      end
    end
  end

  // Compare process: every write strobe and every TX byte is checked against the model queues.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (cpu_enable) en_cycles++;
        if (imem_we) begin
          if (im_data_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL imem_unexpected actual=addr %0d data %h required=no write", imem_addr, imem_wdata);
          end else begin
            chk("imem_addr", 32'(imem_addr), im_addr_q.pop_front());
            chk("imem_data", imem_wdata, im_data_q.pop_front());
          end
        end
        if (tx_signal) begin
          tx_pulses++;
          if (dump_pulses < 4) first_bytes[dump_pulses] = tx_data;
          dump_pulses++;
          if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected actual=%h required=no byte", tx_data);
          end else begin
            chk("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_en;
    int base_tx;
    int n;
    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
      dmem[i] = 32'hD000_0000 + 32'(i) * 32'h0000_0011;
    end

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_tx_signal", 32'(tx_signal), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_enable", 32'(cpu_enable), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_dmem_addr", 32'(dmem_addr), 32'd0);
    reset = 1'b0;

    // Program load ending in HALT
    load_word(32'h1234_5678, 0);
    load_word(32'hDEAD_BEEF, 1);
    load_word(32'h0000_0013, 2);
    load_word(32'hFC00_0000, 3);
    repeat (5) @(negedge clock);
    chk("load_pending", 32'(im_data_q.size()), 32'd0);
    chk("load_last_addr", 32'(imem_addr), 32'd3);
    chk("load_last_data", imem_wdata, 32'hFC00_0000);

    // Unknown command
    base_en = en_cycles;
    base_tx = tx_pulses;
    send_byte(8'h00);
    repeat (10) @(negedge clock);
    chk("ignore_enable", 32'(en_cycles - base_en), 32'd0);
    chk("ignore_tx", 32'(tx_pulses - base_tx), 32'd0);

    // Single step and dump
    pc = 32'h0000_0004;
    push_dump(pc);
    dump_pulses = 0;
    base_en = en_cycles;
    base_tx = tx_pulses;
    send_byte(8'hAA);
    wait_dump_done("step_dump_left");
    chk("step_enable_cycles", 32'(en_cycles - base_en), 32'd1);
    chk("step_tx_count", 32'(tx_pulses - base_tx), 32'd260);
    chk("step_byte0", 32'(first_bytes[0]), 32'h04);
    chk("step_byte1", 32'(first_bytes[1]), 32'h00);
    chk("step_byte2", 32'(first_bytes[2]), 32'h00);
    chk("step_byte3", 32'(first_bytes[3]), 32'h00);

    // Run until HALT, dump, then halted
    pc = 32'h0000_0028;
    push_dump(pc);
    dump_pulses = 0;
    base_en = en_cycles;
    base_tx = tx_pulses;
    run_cnt = 0;
    halt_arm = 1;
    send_byte(8'hFF);
    wait_dump_done("run_dump_left");
    chk("run_enable_cycles", 32'(en_cycles - base_en), 32'd40);
    chk("run_tx_count", 32'(tx_pulses - base_tx), 32'd260);
    base_en = en_cycles;
    base_tx = tx_pulses;
    send_byte(8'hAA);
    repeat (20) @(negedge clock);
    chk("halted_enable", 32'(en_cycles - base_en), 32'd0);
    chk("halted_tx", 32'(tx_pulses - base_tx), 32'd0);

    // Reset in the middle of a dump
    halt = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    load_word(32'hFC00_0000, 0);
    pc = 32'h0000_0008;
    push_dump(pc);
    dump_pulses = 0;
    send_byte(8'hAA);
    n = 0;
    while (dump_pulses < 100 && n < 3000) begin
      @(posedge clock);
      #2;
      n++;
    end
    chk("abort_reach_byte100", 32'(dump_pulses), 32'd100);
    reset = 1'b1;
    #1;
    chk("abort_tx_signal", 32'(tx_signal), 32'd0);
    chk("abort_cpu_enable", 32'(cpu_enable), 32'd0);
    chk("abort_tx_data", 32'(tx_data), 32'd0);
    tx_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Full 32-word load with address wrap
    for (int i = 0; i < 32; i++) load_word(32'h1111_0000 + 32'(i), i);
    repeat (5) @(negedge clock);
    chk("wrap_pending", 32'(im_data_q.size()), 32'd0);
    chk("wrap_last_addr", 32'(imem_addr), 32'd31);
    base_en = en_cycles;
    base_tx = tx_pulses;
    send_byte(8'h00);
    repeat (10) @(negedge clock);
    chk("wrap_ignore_tx", 32'(tx_pulses - base_tx), 32'd0);
    push_dump(pc);
    send_byte(8'hAA);
    wait_dump_done("wrap_step_dump_left");
    chk("wrap_step_enable", 32'(en_cycles - base_en), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
